// File: rtl/key_debounce_multi_if.sv
// key_debounce_multi_if
//   Bundles the key front-end signals between the board-side driver (master)
//   and the debouncer (slave).
//   key_in       raw button levels, one bit per channel
//   repeat_en    auto-repeat enable level
//   key_value    debounced pressed state per channel (1 = pressed)
//   key_flag     one-cycle press / auto-repeat pulse per channel
//   key_rel      one-cycle release pulse per channel
//   key_code     index of the lowest channel with key_flag set
//   key_code_vld OR of key_flag
interface key_debounce_multi_if #(
  parameter int CH = 4
) ();
  localparam int CODE_W = $clog2(CH);

  logic [CH-1:0]     key_in;
  logic              repeat_en;
  logic [CH-1:0]     key_value;
  logic [CH-1:0]     key_flag;
  logic [CH-1:0]     key_rel;
  logic [CODE_W-1:0] key_code;
  logic              key_code_vld;

  modport master (
    output key_in,
    output repeat_en,
    input  key_value,
    input  key_flag,
    input  key_rel,
    input  key_code,
    input  key_code_vld
  );

  modport slave (
    input  key_in,
    input  repeat_en,
    output key_value,
    output key_flag,
    output key_rel,
    output key_code,
    output key_code_vld
  );
endinterface

// File: rtl/key_debounce_multi.sv
// key_debounce_multi
//   Multi-channel button front end: 2-flop synchroniser, per-channel debounce
//   counter, press/release pulses, optional auto-repeat per channel and a
//   lowest-index winner code for the game logic.
//   sys_clk  single clock, rising edge
//   sys_rst  synchronous active-high reset
//   kif      slave side of key_debounce_multi_if (key_in, repeat_en in;
//            key_value, key_flag, key_rel, key_code, key_code_vld out)
module key_debounce_multi #(
  parameter int CH           = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int REPEAT_DLY   = 12500000,
  parameter int REPEAT_PER   = 2500000,
  parameter int CNT_W        = 24
) (
  input logic                 sys_clk,
  input logic                 sys_rst,
  key_debounce_multi_if.slave kif
);

  localparam int CODE_W = $clog2(CH);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PER - 1);
  // Raw level of a key that is not pressed.
  localparam logic [CH-1:0] RELEASED = (ACTIVE_LOW != 0) ? {CH{1'b1}} : {CH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD_DLY = 2'd1,
    ST_HOLD_RPT = 2'd2
  } rpt_state_e;

  logic [CH-1:0]     sync1_q;
  logic [CH-1:0]     sync2_q;
  logic [CH-1:0]     pressed_s;
  logic [CH-1:0]     value_q;
  logic [CH-1:0]     value_d;
  logic [CH-1:0]     flag_q;
  logic [CH-1:0]     flag_d;
  logic [CH-1:0]     rel_q;
  logic [CH-1:0]     rel_d;
  logic [CH-1:0]     press_acc_s;
  logic [CNT_W-1:0]  db_cnt_q [CH];
  logic [CNT_W-1:0]  db_cnt_d [CH];
  logic [CNT_W-1:0]  rc_q     [CH];
  logic [CNT_W-1:0]  rc_d     [CH];
  rpt_state_e        state_q  [CH];
  rpt_state_e        state_d  [CH];
  logic [CODE_W-1:0] code_s;

  // Synchronised level with polarity normalised so that 1 means pressed.
  assign pressed_s = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  // Debounce: count while the synchronised level disagrees with the stable
  // level; any agreement restarts the window from zero.
  always_comb begin
    value_d     = value_q;
    rel_d       = '0;
    press_acc_s = '0;
    db_cnt_d    = db_cnt_q;
    for (int i = 0; i < CH; i++) begin
      if (pressed_s[i] == value_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_cnt_d[i]    = '0;
        value_d[i]     = pressed_s[i];
        press_acc_s[i] = pressed_s[i];
        rel_d[i]       = ~pressed_s[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Repeat FSM next state; an accepted release takes priority over a repeat
  // pulse due in the same cycle, so the two never coincide.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    flag_d  = press_acc_s;
    for (int i = 0; i < CH; i++) begin
      case (state_q[i])
        ST_IDLE: begin
          rc_d[i] = '0;
          if (press_acc_s[i]) begin
            state_d[i] = ST_HOLD_DLY;
          end else begin
            state_d[i] = ST_IDLE;
          end
        end
        ST_HOLD_DLY, ST_HOLD_RPT: begin
          if (rel_d[i]) begin
            state_d[i] = ST_IDLE;
            rc_d[i]    = '0;
          end else if (!kif.repeat_en) begin
            // Disabled: hold at zero so re-enable restarts a full interval.
            rc_d[i] = '0;
          end else if (rc_q[i] == ((state_q[i] == ST_HOLD_DLY) ? RD_LAST : RP_LAST)) begin
            flag_d[i]  = 1'b1;
            rc_d[i]    = '0;
            state_d[i] = ST_HOLD_RPT;
          end else begin
            rc_d[i] = rc_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          rc_d[i]    = '0;
        end
      endcase
    end
  end

  // Lowest set key_flag bit wins; scanning downward lets lower indices override.
  always_comb begin
    code_s = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      code_s = flag_q[i] ? CODE_W'(i) : code_s;
    end
  end

  // State registers: synchroniser, stable values, pulses, counters, FSMs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1_q <= RELEASED;
      sync2_q <= RELEASED;
      value_q <= '0;
      flag_q  <= '0;
      rel_q   <= '0;
      for (int i = 0; i < CH; i++) begin
        db_cnt_q[i] <= '0;
        rc_q[i]     <= '0;
        state_q[i]  <= ST_IDLE;
      end
    end else begin
      sync1_q <= kif.key_in;
      sync2_q <= sync1_q;
      value_q <= value_d;
      flag_q  <= flag_d;
      rel_q   <= rel_d;
      for (int i = 0; i < CH; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
        rc_q[i]     <= rc_d[i];
        state_q[i]  <= state_d[i];
      end
    end
  end

  assign kif.key_value    = value_q;
  assign kif.key_flag     = flag_q;
  assign kif.key_rel      = rel_q;
  assign kif.key_code     = code_s;
  assign kif.key_code_vld = |flag_q;

endmodule

// File: doc/key_debounce_multi.md
# key_debounce_multi

Parametrised multi-channel key front end that replaces the four per-direction single-key debouncers feeding the snake game logic. It synchronises CH raw button inputs and debounces each channel with its own counter. It emits press and release pulses, and optionally emits auto-repeat press pulses while a key is held. It also outputs the index of the winning pressed key, so game logic receives one direction event per cycle. It sits between the board buttons and the display/game-control block, in the 25 MHz pixel-clock domain.

## Interface
- CH, 4: number of key channels (≥2)
- ACTIVE_LOW, 1: 1 means a pressed key reads 0 on key_in; 0 means a pressed key reads 1
- DEBOUNCE_CYC, 500000: cycles an input must stay at its new level before it is accepted (20 ms at 25 MHz)
- REPEAT_DLY, 12500000: cycles from the press pulse to the first auto-repeat pulse (500 ms)
- REPEAT_PER, 2500000: cycles between subsequent auto-repeat pulses (100 ms)
- CNT_W, 24: counter width; must hold max(DEBOUNCE_CYC, REPEAT_DLY, REPEAT_PER)
- sys_clk  in  1  single clock; all logic is on the rising edge
- sys_rst  in  1  synchronous reset, active-high
- key_in  in  CH  raw asynchronous button levels
- repeat_en  in  1  auto-repeat mode enable; level input, synchronous to sys_clk
- key_value  out  CH  debounced state per channel, 1 = pressed, polarity normalised
- key_flag  out  CH  one-cycle pulse on accepted press and on each auto-repeat
- key_rel  out  CH  one-cycle pulse on accepted release
- key_code  out  $clog2(CH)  index of the lowest-numbered channel with key_flag high
- key_code_vld  out  1  equals OR of key_flag

## Operation
- Synchroniser
  - Each channel passes through a 2-flop synchroniser.
  - The synchroniser output is then polarity-normalised so that 1 means pressed.
- Debounce counter (per channel)
  - While the synchronised value equals the stable value, the counter is held at 0.
  - While the two values differ, the counter increments.
  - When the counter reaches DEBOUNCE_CYC-1 and the values still differ: the stable value takes the new level and the counter clears.
  - Any return to the stable level before that point clears the counter, so a bounce restarts the full window.
- Stable value outputs
  - key_value is the stable value.
  - A 0→1 transition of the stable value pulses key_flag in the same cycle key_value rises.
  - A 1→0 transition pulses key_rel in the same cycle key_value falls.
- Repeat FSM (per channel), states IDLE, HOLD_DLY, HOLD_RPT; repeat counter rc
  - IDLE→HOLD_DLY on accepted press; rc cleared.
  - HOLD_DLY: rc increments while repeat_en=1. When rc reaches REPEAT_DLY-1, key_flag pulses, rc clears, and the state goes to HOLD_RPT.
  - HOLD_RPT: the same behaviour, with period REPEAT_PER.
  - repeat_en=0 holds rc at 0 and suppresses repeat pulses. After re-enable, a full REPEAT_DLY or REPEAT_PER is counted from the first enabled cycle.
  - Any state→IDLE on accepted release. A repeat pulse never coincides with key_rel.
- Code output
  - key_code and key_code_vld are combinational from the key_flag register.
  - On simultaneous flags the lowest index wins; all flags remain visible on key_flag.
  - key_code=0 when key_code_vld=0.

## Timing
- Reset behaviour
  - Synchroniser flops reset to the released level.
  - All counters reset to 0, all FSMs to IDLE.
  - key_value, key_flag, key_rel, key_code and key_code_vld are all 0 in the cycle after sys_rst is sampled high, and stay 0 while it is held.
- Press and release latency
  - If key_in is at a new level from cycle t onward, key_value changes and key_flag/key_rel pulse at cycle t+2+DEBOUNCE_CYC.
- Repeat latency
  - First repeat pulse at press-pulse cycle + REPEAT_DLY.
  - Later repeat pulses every REPEAT_PER cycles.
- Reset mid-operation aborts the debounce and repeat timing.
  - A key held through reset is re-debounced from scratch after reset, because the synchronisers restart from the released level.
  - Its press pulse appears at deassert+2+DEBOUNCE_CYC.
- Channel independence
  - Channels are fully independent; no channel's timing depends on another.

## Test plan
All scenarios use CH=4, ACTIVE_LOW=1, DEBOUNCE_CYC=8, REPEAT_DLY=20, REPEAT_PER=5.
- Clean press: key_in[1] goes 0 at cycle 100, held → key_value[1]=1 and a single key_flag[1] pulse at cycle 110, key_code=1, key_code_vld=1 for that cycle only. Release at cycle 200 → key_rel[1] pulse at cycle 210.
- Bounce: key_in[2] toggles every 3 cycles from cycle 100 to 130, then settles low at cycle 130 → exactly one key_flag[2] pulse, at cycle 140; no key_rel pulse.
- Auto-repeat: repeat_en=1, key_in[3] held low from cycle 100 → key_flag[3] pulses at 110, 130, 135, 140… Release at 150 → key_rel[3] at 160 and no pulses after 160.
- Simultaneous press: key_in[0] and key_in[3] both go low at cycle 100 → key_flag=4'b1001, key_code=0 at cycle 110.
- Reset mid-debounce: key_in[1] goes low at cycle 100; sys_rst is high on cycles 105–106 → all outputs 0 through cycle 107. The key stays held, so key_flag[1] pulses at cycle 117.
- Repeat gating: key held with repeat_en=1 through its first repeat pulse; repeat_en then drops for 30 cycles → no pulses during that time. The first pulse after re-enable comes exactly REPEAT_PER cycles after repeat_en returns high.
